avg_pool2d_stream_ctrl: RTL
===========================

# avg_pool2d_stream_ctrl

Streaming sequencer for 2-D average pooling: consumes one pixel per handshake in raster order (row-major, one channel, `DATA_IN_0_WIDTH` × `DATA_IN_0_HEIGHT` per frame) and emits one pooled value per output window, also in raster order. Row/column counters decide which input pixels fall in which kernel window. A bank of per-output-column accumulators holds partial window sums across input rows, so no full frame buffer is needed. It sits between a pixel-stream producer and the next layer, in place of a fully-parallel pooling datapath.

## Interface
- `DATA_IN_0_PRECISION_0`, 8, pixel width in bits, signed two's complement.
- `DATA_IN_0_PRECISION_1`, 3, fractional bits; carried through unchanged.
- `DATA_IN_0_WIDTH`, 8, frame width W in pixels.
- `DATA_IN_0_HEIGHT`, 8, frame height H in pixels.
- `KERNEL_WIDTH`, 2, KW.
- `KERNEL_HEIGHT`, 2, KH.
- `STRIDE`, 2, S, same in both dimensions.
- Legality:
  - S ≥ KW and S ≥ KH (no window overlap).
  - KW·KH is a power of two.
  - W ≥ KW and H ≥ KH.
- `DATA_OUT_0_PRECISION_0` / `DATA_OUT_0_PRECISION_1` must equal the input values; an illegal set raises an elaboration `$error`.
- Derived values:
  - OUT_W = (W−KW)/S+1 and OUT_H = (H−KH)/S+1 (integer division).
  - ACC_W = PRECISION_0 + log2(KW·KH).
  - SH = log2(KW·KH).
- Ports (name, direction, width, meaning):
  - `clk` in 1, clock.
  - `rst` in 1, reset; asynchronous, active-high.
  - `data_in_0` in PRECISION_0, pixel.
  - `data_in_0_valid` in 1, input valid.
  - `data_in_0_ready` out 1, input ready.
  - `data_out_0` out PRECISION_0, pooled value.
  - `data_out_0_valid` out 1, output valid.
  - `data_out_0_ready` in 1, output ready.

## Operation
- **Accept:** a pixel is accepted when `data_in_0_valid && data_in_0_ready`.
- **Position counters:** all advance only on accept.
  - `col` counts 0..W−1 and `row` counts 0..H−1.
  - `cph`/`oc` are the column phase (0..S−1) and output-column index; `rph`/`orow` are the row phase and output-row index.
  - Phase and index counters are incremented; no divider is used.
- **Window membership:** a pixel is in-window iff `cph<KW && oc<OUT_W && rph<KH && orow<OUT_H`. Out-of-window pixels (stride gap, right/bottom remainder) are accepted and dropped.
- **Accumulation:**
  - In-window pixel: `acc[oc] += sign_extend(pixel)` at ACC_W bits; overflow is impossible by construction.
  - The first pixel of a window (`cph==0 && rph==0`) loads rather than adds, so no clear pass is needed.
- **Window completion** (`cph==KW−1 && rph==KH−1`, in-window):
  - result = (acc[oc] + pixel) >>> SH, an arithmetic shift, i.e. floor toward −∞.
  - Truncate to PRECISION_0; this is lossless because the mean lies within the input range.
  - Load the output register and set `data_out_0_valid`.
- **Output register:**
  - Single entry, with two states: EMPTY (valid=0) and FULL (valid=1).
  - EMPTY→FULL on window completion.
  - FULL→EMPTY on `data_out_0_ready` with no simultaneous completion.
  - FULL→FULL (new value) when drain and completion coincide.
- **Ready rule:** `data_in_0_ready = !data_out_0_valid || data_out_0_ready`. This is a combinational path from `data_out_0_ready`. Non-completing pixels are also stalled while FULL; this is accepted as a simplicity trade.
- **End of frame:** after accepting (row=H−1, col=W−1), all counters wrap to 0 in the same cycle. The next frame starts with no idle cycle. Accumulator contents are stale but are overwritten by the load-on-first rule.
- **Reset (any time, including mid-frame):**
  - All counters and `acc[]` go to 0.
  - `data_out_0` = 0 and `data_out_0_valid` = 0.
  - Since `data_out_0_valid` = 0, `data_in_0_ready` = 1.
  - Any partial frame is discarded; the first pixel after reset is treated as (0,0).

## Timing
- Latency: `data_out_0_valid` rises the cycle after the completing pixel is accepted.
- Throughput: one pixel per cycle while the output is drained each cycle.
- `data_out_0` is stable while valid && !ready (AXI-style hold). The input side obeys the same rule at the producer.
- Output order is raster order over (orow, oc). A frame produces exactly OUT_W·OUT_H outputs.

## Test plan
- **Basic 4×4 frame:** W=H=4, KW=KH=S=2, pixels 0..15, out_ready=1 → outputs 2, 4, 10, 12 (sums 10, 18, 42, 50). Valid one cycle after pixels 5, 7, 13, 15.
- **Negative rounding:** all pixels −3 → −3 ×4. A window {−1,0,0,0} → −1 (floor). A window {1,0,0,0} → 0.
- **Stride gap:** W=H=5, KW=KH=2, S=3, pixel = 10·row+col → 4 outputs: 5, 8, 35, 38. Column 2 and row 2 are dropped; 25 inputs are accepted.
- **Backpressure:** hold out_ready=0 for 5 cycles when the first output appears → in_ready=0 and the value is held. On release, the sequence is identical to the basic frame and no pixel is lost.
- **Back-to-back frames and mid-frame reset:**
  - Two consecutive 4×4 frames with no gap → 8 outputs, and the second frame matches the first.
  - Assert rst after pixel 6 of a frame → valid=0 and ready=1 immediately. A fresh full frame then yields 2, 4, 10, 12.

Source files
------------

// File: rtl/avg_pool2d_stream_ctrl_if.sv
// Valid/ready stream bundle carrying one pixel or pooled value per handshake.
interface avg_pool2d_stream_ctrl_if #(
  parameter int unsigned DataWidth = 8
);
  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/avg_pool2d_stream_ctrl.sv
// Streaming 2-D average pooling: raster-order pixels in, raster-order window means out,
// with one partial-sum accumulator per output column instead of a frame buffer.
module avg_pool2d_stream_ctrl #(
  parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
  parameter int unsigned DATA_IN_0_PRECISION_1  = 3,
  parameter int unsigned DATA_IN_0_WIDTH        = 8,
  parameter int unsigned DATA_IN_0_HEIGHT       = 8,
  parameter int unsigned KERNEL_WIDTH           = 2,
  parameter int unsigned KERNEL_HEIGHT          = 2,
  parameter int unsigned STRIDE                 = 2,
  parameter int unsigned DATA_OUT_0_PRECISION_0 = 8,
  parameter int unsigned DATA_OUT_0_PRECISION_1 = 3
) (
  input logic                      clk,
  input logic                      rst,
  avg_pool2d_stream_ctrl_if.slave  data_in_0,
  avg_pool2d_stream_ctrl_if.master data_out_0
);

  localparam int unsigned P0       = DATA_IN_0_PRECISION_0;
  localparam int unsigned W        = DATA_IN_0_WIDTH;
  localparam int unsigned H        = DATA_IN_0_HEIGHT;
  localparam int unsigned KW       = KERNEL_WIDTH;
  localparam int unsigned KH       = KERNEL_HEIGHT;
  localparam int unsigned S        = STRIDE;
  localparam int unsigned OutW     = (W - KW) / S + 1;
  localparam int unsigned OutH     = (H - KH) / S + 1;
  localparam int unsigned KArea    = KW * KH;
  localparam int unsigned Sh       = $clog2(KArea);
  localparam int unsigned AccW     = P0 + Sh;
  localparam int unsigned ColW     = $clog2(W + 1);
  localparam int unsigned RowW     = $clog2(H + 1);
  localparam int unsigned PhW      = $clog2(S + 1);
  localparam int unsigned AccIdxW  = (OutW > 1) ? $clog2(OutW) : 1;
  localparam int unsigned AccDepth = 2 ** AccIdxW;

  if (S < KW || S < KH) begin : g_err_overlap
    $error("avg_pool2d_stream_ctrl: STRIDE must be >= both kernel dimensions");
  end
  if ((KArea & (KArea - 1)) != 0) begin : g_err_area
    $error("avg_pool2d_stream_ctrl: KERNEL_WIDTH*KERNEL_HEIGHT must be a power of two");
  end
  if (W < KW || H < KH) begin : g_err_frame
    $error("avg_pool2d_stream_ctrl: frame smaller than kernel");
  end
  if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 ||
      DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_err_prec
    $error("avg_pool2d_stream_ctrl: output precision must equal input precision");
  end

  typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

  logic [ColW-1:0] col_q, col_d, oc_q, oc_d;
  logic [RowW-1:0] row_q, row_d, orow_q, orow_d;
  logic [PhW-1:0]  cph_q, cph_d, rph_q, rph_d;

  logic signed [AccW-1:0] acc_q [AccDepth];
  logic signed [AccW-1:0] pix_ext;
  logic signed [AccW-1:0] acc_sum;
  logic [AccIdxW-1:0]     acc_idx;

  out_state_e    out_st_q;
  logic [P0-1:0] out_data_q;

  logic accept, in_window, win_first, win_last, complete;

  assign data_in_0.ready  = (out_st_q == StEmpty) || data_out_0.ready;
  assign data_out_0.valid = (out_st_q == StFull);
  assign data_out_0.data  = out_data_q;

  assign accept    = data_in_0.valid && data_in_0.ready;
  assign in_window = (cph_q < PhW'(KW)) && (oc_q < ColW'(OutW)) &&
                     (rph_q < PhW'(KH)) && (orow_q < RowW'(OutH));
  assign win_first = (cph_q == '0) && (rph_q == '0);
  assign win_last  = (cph_q == PhW'(KW - 1)) && (rph_q == PhW'(KH - 1));
  assign complete  = accept && in_window && win_last;

  assign acc_idx = oc_q[AccIdxW-1:0];
  assign pix_ext = AccW'($signed(data_in_0.data));
  // The first pixel of a window loads, so stale sums from a previous frame never leak in.
  assign acc_sum = (win_first ? '0 : acc_q[acc_idx]) + pix_ext;

  always_comb begin
    col_d  = col_q;
    cph_d  = cph_q;
    oc_d   = oc_q;
    row_d  = row_q;
    rph_d  = rph_q;
    orow_d = orow_q;
    if (accept) begin
      if (col_q == ColW'(W - 1)) begin
        col_d = '0;
        cph_d = '0;
        oc_d  = '0;
        if (row_q == RowW'(H - 1)) begin
          row_d  = '0;
          rph_d  = '0;
          orow_d = '0;
        end else begin
          row_d = row_q + RowW'(1);
          if (rph_q == PhW'(S - 1)) begin
            rph_d  = '0;
            orow_d = orow_q + RowW'(1);
          end else begin
            rph_d = rph_q + PhW'(1);
          end
        end
      end else begin
        col_d = col_q + ColW'(1);
        if (cph_q == PhW'(S - 1)) begin
          cph_d = '0;
          oc_d  = oc_q + ColW'(1);
        end else begin
          cph_d = cph_q + PhW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      cph_q  <= '0;
      oc_q   <= '0;
      row_q  <= '0;
      rph_q  <= '0;
      orow_q <= '0;
    end else begin
      col_q  <= col_d;
      cph_q  <= cph_d;
      oc_q   <= oc_d;
      row_q  <= row_d;
      rph_q  <= rph_d;
      orow_q <= orow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < AccDepth; i++) begin
        acc_q[i] <= '0;
      end
    end else if (accept && in_window) begin
      acc_q[acc_idx] <= acc_sum;
    end
  end

  // Arithmetic shift floors toward -inf; the mean always fits back into P0 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_st_q   <= StEmpty;
      out_data_q <= '0;
    end else begin
      unique case (out_st_q)
        StEmpty: begin
          if (complete) begin
            out_st_q   <= StFull;
            out_data_q <= P0'(acc_sum >>> Sh);
          end
        end
        StFull: begin
          if (complete) begin
            out_data_q <= P0'(acc_sum >>> Sh);
          end else if (data_out_0.ready) begin
            out_st_q <= StEmpty;
          end
        end
        default: out_st_q <= StEmpty;
      endcase
    end
  end

endmodule
